// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the I/D caches and the fill
//               controller that sits between them and main memory.
// Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;
    localparam int FILL_CNT_W        = WORD_IDX_BITS + 1;

    localparam logic DST_I = 1'b0;
    localparam logic DST_D = 1'b1;

    // Byte offset of a 16-bit word within its block.
    function automatic logic [BLOCK_OFFSET_BITS-1:0] word_offset(
        input logic [WORD_IDX_BITS-1:0] idx
    );
        return {idx, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
// Module      : fill_counter
// Description : Block word counter with synchronous clear, enable and a
//               terminal flag that saturates the count at TERM.
// Revision    : 1.0  initial release
// ============================================================================
module fill_counter
    import cache_pkg::*;
#(
    parameter int TERM = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    output logic [WORD_IDX_BITS-1:0] o_idx,
    output logic                     o_term
);

    localparam logic [FILL_CNT_W-1:0] c_TERM = FILL_CNT_W'(TERM);

    logic [FILL_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_term) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_idx  = r_count[WORD_IDX_BITS-1:0];
    assign o_term = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_ctrl
// Description : Serializes I/D cache misses and D-side write-through stores
//               onto one pipelined memory port and streams block fills back.
// Revision    : 1.0  initial release
// ============================================================================
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss,
    input  logic [ADDR_W-1:0]        i_miss_addr,
    input  logic                     d_miss,
    input  logic [ADDR_W-1:0]        d_miss_addr,
    input  logic                     d_wr,
    input  logic [ADDR_W-1:0]        d_wr_addr,
    input  logic [DATA_W-1:0]        d_wr_data,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_valid,
    output logic                     fill_we,
    output logic                     fill_dst,
    output logic [WORD_IDX_BITS-1:0] fill_idx,
    output logic [ADDR_W-1:0]        fill_tag_addr,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     fill_done,
    output logic                     d_wr_done
);

    generate
        if (WORDS_PER_BLOCK != (1 << WORD_IDX_BITS) || MEM_LATENCY < 1 ||
            ADDR_W <= BLOCK_OFFSET_BITS) begin : g_param_check
            $error("cache_fill_ctrl: unsupported block geometry or latency");
        end
    endgenerate

    fill_state_t               r_state;
    logic [ADDR_W-1:0]         r_base;
    logic                      r_dst;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [DATA_W-1:0]         r_wr_data;

    logic                      w_in_fill;
    logic                      w_cnt_clr;
    logic                      w_iss_en;
    logic                      w_iss_term;
    logic [WORD_IDX_BITS-1:0]  w_iss_idx;
    logic                      w_rcv_en;
    logic                      w_rcv_term;
    logic [WORD_IDX_BITS-1:0]  w_rcv_idx;
    logic                      w_rcv_last;

    assign w_in_fill  = (r_state == ST_FILL);
    assign w_cnt_clr  = !w_in_fill;
    assign w_iss_en   = w_in_fill && !w_iss_term;
    // Returns are accepted only while filling; stray or post-reset ones vanish.
    assign w_rcv_en   = w_in_fill && mem_valid && !w_rcv_term;
    assign w_rcv_last = w_rcv_en && (&w_rcv_idx);

    fill_counter #(.TERM(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_iss_en),
        .o_idx  (w_iss_idx),
        .o_term (w_iss_term)
    );

    fill_counter #(.TERM(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_rcv_en),
        .o_idx  (w_rcv_idx),
        .o_term (w_rcv_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_dst     <= DST_I;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                // Data side first: the M-stage request is older than F-stage.
                ST_IDLE: begin
                    if (d_wr) begin
                        r_state   <= ST_WRITE;
                        r_wr_addr <= d_wr_addr;
                        r_wr_data <= d_wr_data;
                    end else if (d_miss) begin
                        r_state <= ST_FILL;
                        r_dst   <= DST_D;
                        r_base  <= {d_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS],
                                    {BLOCK_OFFSET_BITS{1'b0}}};
                    end else if (i_miss) begin
                        r_state <= ST_FILL;
                        r_dst   <= DST_I;
                        r_base  <= {i_miss_addr[ADDR_W-1:BLOCK_OFFSET_BITS],
                                    {BLOCK_OFFSET_BITS{1'b0}}};
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_FILL: begin
                    if (w_rcv_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = r_wr_addr;
                mem_wdata = r_wr_data;
            end
            ST_FILL: begin
                if (w_iss_en) begin
                    mem_en   = 1'b1;
                    // OR, not add: the block base has a zero offset field.
                    mem_addr = r_base | ADDR_W'(word_offset(w_iss_idx));
                end
            end
            default: begin
            end
        endcase
    end

    assign fill_we       = w_rcv_en;
    assign fill_dst      = r_dst;
    assign fill_idx      = w_rcv_idx;
    assign fill_tag_addr = r_base;
    assign fill_data     = w_rcv_en ? mem_rdata : '0;
    assign fill_done     = (r_state == ST_DONE);
    assign d_wr_done     = (r_state == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_ctrl
// Description : Self-checking bench for cache_fill_ctrl with a 4-stage
//               pipelined memory model and a fill/read/write scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = '0;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = '0;
    logic        d_wr = 1'b0;
    logic [15:0] d_wr_addr = '0;
    logic [15:0] d_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;
    logic        fill_we, fill_dst, fill_done, d_wr_done;
    logic [2:0]  fill_idx;
    logic [15:0] fill_tag_addr, fill_data;

    cache_fill_ctrl #(
        .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_dst(fill_dst), .fill_idx(fill_idx),
        .fill_tag_addr(fill_tag_addr), .fill_data(fill_data),
        .fill_done(fill_done), .d_wr_done(d_wr_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic        dst;
        logic [2:0]  idx;
        logic [15:0] tag;
        logic [15:0] data;
    } fill_exp_t;

    typedef struct {
        int          kind;      // 0 = I miss, 1 = D miss, 2 = store
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_tag;
        int          exp_lat;
    } vec_t;

    fill_exp_t   exp_fill [$];
    logic [15:0] exp_rd [$];
    logic [31:0] exp_wr [$];
    fill_exp_t   mon_fe;
    logic [15:0] mon_ra;
    logic [31:0] mon_wa;

    // Memory: sparse written words over a fixed address-derived pattern.
    logic [15:0] mem_q [logic [15:0]];
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (mem_en && mem_wr) mem_q[mem_addr] = mem_wdata;
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pd[0] <= mem_read(mem_addr);
        for (int k = 1; k < 4; k++) pd[k] <= pd[k-1];
    end

    assign mem_valid = pv[3];
    assign mem_rdata = pv[3] ? pd[3] : 16'hDEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fill_we) begin
            if (exp_fill.size() == 0) begin
                chk("unexpected_fill_we", 1, 0);
            end else begin
                mon_fe = exp_fill.pop_front();
                chk("fill_word", {fill_dst, fill_idx, fill_tag_addr, fill_data},
                    {mon_fe.dst, mon_fe.idx, mon_fe.tag, mon_fe.data});
            end
        end
        if (mem_en && !mem_wr) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_mem_read", {16'h0, mem_addr}, 0);
            end else begin
                mon_ra = exp_rd.pop_front();
                chk("mem_read_addr", mem_addr, mon_ra);
            end
        end
        if (mem_en && mem_wr) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_mem_write", {mem_addr, mem_wdata}, 0);
            end else begin
                mon_wa = exp_wr.pop_front();
                chk("mem_write", {mem_addr, mem_wdata}, mon_wa);
                chk("wr_done_with_write", d_wr_done, 1);
            end
        end
    end

    task automatic push_fill(input logic is_d, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        fill_exp_t   e;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(2 * k);
            exp_rd.push_back(a);
            e.dst  = is_d;
            e.idx  = 3'(k);
            e.tag  = base;
            e.data = mem_read(a);
            exp_fill.push_back(e);
        end
    endtask

    // Returns the number of negedges until the pulse, 0 if it never came.
    task automatic wait_sig(input logic which, input int maxc, output int lat);
        lat = 0;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            if ((which ? d_wr_done : fill_done) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {mem_en, mem_wr, fill_we, fill_dst, fill_idx, fill_done, d_wr_done}, 0);
        chk({name, "_bus"}, {mem_addr, mem_wdata, fill_tag_addr, fill_data}, 0);
    endtask

    task automatic run_miss(input logic is_d, input logic [15:0] addr,
                            input logic [15:0] exp_tag, input int exp_lat, input string name);
        int lat;
        push_fill(is_d, addr);
        if (is_d) begin d_miss_addr = addr; d_miss = 1'b1; end
        else      begin i_miss_addr = addr; i_miss = 1'b1; end
        wait_sig(1'b0, 40, lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_dst_tag"}, {fill_dst, fill_tag_addr}, {is_d, exp_tag});
        d_miss = 1'b0;
        i_miss = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [15:0] data,
                             input int exp_lat, input string name);
        int lat;
        exp_wr.push_back({addr, data});
        d_wr_addr = addr;
        d_wr_data = data;
        d_wr      = 1'b1;
        wait_sig(1'b1, 10, lat);
        chk({name, "_lat"}, lat, exp_lat);
        d_wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   lat;
        int   found;
        int   n_we, n_done, n_valid;

        vecs[0] = '{0, 16'h1236, 16'h0000, 16'h1230, 13};
        vecs[1] = '{1, 16'h8002, 16'h0000, 16'h8000, 13};
        vecs[2] = '{0, 16'hFFF0, 16'h0000, 16'hFFF0, 13};
        vecs[3] = '{1, 16'hFFFE, 16'h0000, 16'hFFF0, 13};
        vecs[4] = '{2, 16'h0020, 16'h1234, 16'h0000, 1};
        vecs[5] = '{0, 16'h002C, 16'h0000, 16'h0020, 13};
        vecs[6] = '{1, 16'h4567, 16'h0000, 16'h4560, 13};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].kind == 2)
                run_write(vecs[v].addr, vecs[v].wdata, vecs[v].exp_lat, $sformatf("vec%0d_wr", v));
            else
                run_miss(vecs[v].kind == 1, vecs[v].addr, vecs[v].exp_tag,
                         vecs[v].exp_lat, $sformatf("vec%0d_miss", v));
        end

        // Simultaneous misses: D block first, I arbitrated after D's DONE.
        push_fill(1'b1, 16'h8002);
        push_fill(1'b0, 16'h0040);
        d_miss_addr = 16'h8002; d_miss = 1'b1;
        i_miss_addr = 16'h0040; i_miss = 1'b1;
        wait_sig(1'b0, 40, lat);
        chk("dual_d_lat", lat, 13);
        chk("dual_d_dst_tag", {fill_dst, fill_tag_addr}, {1'b1, 16'h8000});
        d_miss = 1'b0;
        wait_sig(1'b0, 40, lat);
        chk("dual_i_lat", lat, 14);
        chk("dual_i_dst_tag", {fill_dst, fill_tag_addr}, {1'b0, 16'h0040});
        i_miss = 1'b0;
        @(negedge clk);

        // Store arriving mid-fill waits for DONE.
        push_fill(1'b0, 16'h0100);
        i_miss_addr = 16'h0100; i_miss = 1'b1;
        repeat (3) @(negedge clk);
        exp_wr.push_back({16'h0010, 16'hBEEF});
        d_wr_addr = 16'h0010; d_wr_data = 16'hBEEF; d_wr = 1'b1;
        wait_sig(1'b0, 40, lat);
        chk("wr_during_fill_done_lat", lat, 10);
        chk("wr_during_fill_dst_tag", {fill_dst, fill_tag_addr}, {1'b0, 16'h0100});
        i_miss = 1'b0;
        wait_sig(1'b1, 10, lat);
        chk("wr_after_done_lat", lat, 2);
        d_wr = 1'b0;
        @(negedge clk);
        chk("mem_0010_holds_beef", mem_read(16'h0010), 16'hBEEF);

        // Store and I miss together: write first, then the fill sees new data.
        exp_wr.push_back({16'h0022, 16'h55AA});
        d_wr_addr = 16'h0022; d_wr_data = 16'h55AA; d_wr = 1'b1;
        i_miss_addr = 16'h0020; i_miss = 1'b1;
        wait_sig(1'b1, 10, lat);
        chk("b2b_wr_lat", lat, 1);
        d_wr = 1'b0;
        @(negedge clk);
        push_fill(1'b0, 16'h0020);
        wait_sig(1'b0, 40, lat);
        chk("b2b_fill_lat", lat, 13);
        chk("b2b_fill_dst_tag", {fill_dst, fill_tag_addr}, {1'b0, 16'h0020});
        i_miss = 1'b0;
        @(negedge clk);

        // Reset at word 4 of a fill; late returns must be dropped.
        push_fill(1'b0, 16'h2000);
        i_miss_addr = 16'h2000; i_miss = 1'b1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (fill_we && fill_idx == 3'd4) begin
                found = 1;
                break;
            end
        end
        chk("rst_word4_reached", found, 1);
        #1 rst = 1'b1;
        #1 chk_all_zero("midfill_reset");
        i_miss = 1'b0;
        exp_fill.delete();
        n_we = 0; n_done = 0; n_valid = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            n_we    += int'(fill_we);
            n_done  += int'(fill_done);
            n_valid += int'(mem_valid);
        end
        chk("late_valid_present", n_valid > 0, 1);
        chk("late_valid_no_fill_we", n_we, 0);
        chk("reset_no_fill_done", n_done, 0);
        run_miss(1'b0, 16'h3008, 16'h3000, 13, "post_reset_miss");

        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("fill_queue_empty", exp_fill.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
